// File: rtl/char_mem_pkg.sv
// Shared constants, FSM encoding and glyph cell indexing
// for the char memory scheduler.
package char_mem_pkg;

  localparam int GLYPH_BITS = 15;
  localparam int ROWS       = 5;
  localparam int COLS       = 3;
  localparam int RD_LAT     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [3:0] idx(
    input logic [1:0] x,
    input logic [2:0] y
  );
    logic [4:0] t;
    t = 5'(y) * 5'd3 + 5'(x) - 5'd1;
    return t[3:0];
  endfunction

endpackage

// File: rtl/char_mem_rd_pipe.sv
// Read-return valid tracker: scan requests delayed by
// the memory read latency, cleared on reset.
module char_mem_rd_pipe
  import char_mem_pkg::*;
(
  input  logic clock,
  input  logic rst,
  input  logic req,
  output logic valid
);

  logic [RD_LAT-1:0] sr;

  always_ff @(posedge clock) begin
    if (rst) sr <= '0;
    else     sr <= {sr[RD_LAT-2:0], req};
  end

  assign valid = sr[RD_LAT-1];

endmodule

// File: rtl/char_mem_sched.sv
// Shares one glyph cell store between VGA scanout reads
// (always first) and a host glyph loader.
module char_mem_sched
  import char_mem_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        scan_req,
  input  logic [1:0]  scan_x,
  input  logic [2:0]  scan_y,
  output logic        scan_pix,
  output logic        scan_pix_valid,
  input  logic        load_valid,
  input  logic [14:0] load_glyph,
  output logic        load_ready,
  output logic        load_done,
  output logic        busy,
  output logic        mem_write,
  output logic [1:0]  mem_x,
  output logic [2:0]  mem_y,
  output logic        mem_data,
  input  logic        mem_rdata
);

  state_t state, state_nx;
  logic [GLYPH_BITS-1:0] glyph;
  logic [1:0] cx;
  logic [2:0] cy;
  logic armed;
  logic accept;
  logic wr_en;
  logic last;

  assign last = (cx == 2'(COLS)) && (cy == 3'(ROWS - 1));

  // armed keeps load_ready low for the first cycle out of reset
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      glyph <= '0;
      cx    <= '0;
      cy    <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nx;
      if (accept) begin
        glyph <= load_glyph;
        cx    <= 2'd1;
        cy    <= 3'd0;
      end else if (wr_en && !last) begin
        if (cx == 2'(COLS)) begin
          cx <= 2'd1;
          cy <= cy + 3'd1;
        end else begin
          cx <= cx + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = armed;
        accept     = load_valid && armed;
        if (accept) state_nx = WRITE;
      end
      WRITE: begin
        busy  = 1'b1;
        wr_en = !scan_req;
        if (wr_en && last) state_nx = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_write = 1'b0;
    mem_x     = 2'd0;
    mem_y     = 3'd0;
    mem_data  = 1'b0;
    if (scan_req) begin
      mem_x = scan_x;
      mem_y = scan_y;
    end else if (wr_en) begin
      mem_write = 1'b1;
      mem_x     = cx;
      mem_y     = cy;
      mem_data  = glyph[idx(cx, cy)];
    end
  end

  char_mem_rd_pipe u_rd_pipe (
    .clock (clock),
    .rst   (rst),
    .req   (scan_req),
    .valid (scan_pix_valid)
  );

  assign scan_pix = scan_pix_valid & mem_rdata;

endmodule

// File: tb/tb_char_mem_sched.sv
// Directed bench for char_mem_sched with a 2-cycle stub
// memory and write/read scoreboards.
module tb_char_mem_sched;

  logic        clock = 1'b0;
  logic        rst;
  logic        scan_req;
  logic [1:0]  scan_x;
  logic [2:0]  scan_y;
  logic        scan_pix;
  logic        scan_pix_valid;
  logic        load_valid;
  logic [14:0] load_glyph;
  logic        load_ready;
  logic        load_done;
  logic        busy;
  logic        mem_write;
  logic [1:0]  mem_x;
  logic [2:0]  mem_y;
  logic        mem_data;
  logic        mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int n;
  int cyc;
  logic [7:0] vbits;

  logic [5:0] wq[$];
  logic       rq[$];

  logic [31:0] mem_bits = '0;
  logic        rd0 = 1'b0;
  logic        rd1 = 1'b0;

  always #5 clock = ~clock;

  char_mem_sched dut (
    .clock          (clock),
    .rst            (rst),
    .scan_req       (scan_req),
    .scan_x         (scan_x),
    .scan_y         (scan_y),
    .scan_pix       (scan_pix),
    .scan_pix_valid (scan_pix_valid),
    .load_valid     (load_valid),
    .load_glyph     (load_glyph),
    .load_ready     (load_ready),
    .load_done      (load_done),
    .busy           (busy),
    .mem_write      (mem_write),
    .mem_x          (mem_x),
    .mem_y          (mem_y),
    .mem_data       (mem_data),
    .mem_rdata      (mem_rdata)
  );

  // stub char memory: address to data_out in two cycles
  always @(posedge clock) begin
    if (mem_write) mem_bits[{mem_y, mem_x}] <= mem_data;
    rd0 <= mem_bits[{mem_y, mem_x}];
    rd1 <= rd0;
  end
  assign mem_rdata = rd1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [5:0] e;
    logic p;
    if (mem_write) begin
      wr_count++;
      chk("wr_no_scan", 32'(scan_req), 32'd0);
      chk("wr_q_nonempty", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_cell", 32'({mem_x, mem_y, mem_data}), 32'(e));
      end
    end
    if (scan_pix_valid) begin
      chk("rd_q_nonempty", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        p = rq.pop_front();
        chk("rd_pix", 32'(scan_pix), 32'(p));
      end
    end
  end

  task automatic push_cells(input logic [14:0] g, input int cnt);
    int k;
    k = 0;
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 1; xx <= 3; xx++) begin
        if (k < cnt)
          wq.push_back({2'(xx), 3'(yy), g[3*yy+xx-1]});
        k++;
      end
  endtask

  task automatic run_load(input logic [14:0] g, input bit stall);
    int c;
    int w0;
    push_cells(g, 15);
    @(posedge clock); #1;
    load_glyph = g;
    load_valid = 1'b1;
    @(negedge clock);
    chk("ld_ready", 32'(load_ready), 32'd1);
    @(posedge clock); #1;
    load_valid = 1'b0;
    w0 = wr_count;
    for (c = 0; c < 40; c++) begin
      scan_req = stall && (c % 2 == 0);
      scan_x = 2'd0;
      scan_y = 3'(c % 5);
      if (scan_req) rq.push_back(1'b0);
      @(negedge clock);
      if (load_done) break;
      @(posedge clock); #1;
    end
    chk("ld_done", 32'(load_done), 32'd1);
    chk("ld_busy_done", 32'(busy), 32'd0);
    chk("ld_cycles", 32'(c), stall ? 32'd30 : 32'd15);
    chk("ld_writes", 32'(wr_count - w0), 32'd15);
    @(posedge clock); #1;
    scan_req = 1'b0;
    @(negedge clock);
    chk("ld_ready_next", 32'({load_ready, load_done}), 32'b10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    scan_req   = 1'b0;
    scan_x     = 2'd0;
    scan_y     = 3'd0;
    load_valid = 1'b0;
    load_glyph = 15'd0;

    repeat (3) @(negedge clock);
    chk("rst_outputs",
        32'({scan_pix, scan_pix_valid, load_ready, load_done,
             busy, mem_write, mem_x, mem_y, mem_data}), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("rst_rel_ready_low", 32'(load_ready), 32'd0);
    @(negedge clock);
    chk("rst_rel_ready", 32'({load_ready, busy}), 32'b10);

    run_load(15'h5A5A, 1'b0);
    run_load(15'h7FFF, 1'b1);
    repeat (3) @(negedge clock);

    @(posedge clock); #1;
    scan_req = 1'b1;
    scan_x = 2'd2;
    scan_y = 3'd1;
    rq.push_back(1'b1);
    @(negedge clock);
    chk("mux_scan", 32'({mem_write, mem_x, mem_y}), 32'({1'b0, 2'd2, 3'd1}));
    chk("rd_lat0", 32'(scan_pix_valid), 32'd0);
    @(posedge clock); #1;
    scan_req = 1'b0;
    @(negedge clock);
    chk("rd_lat1", 32'(scan_pix_valid), 32'd0);
    @(negedge clock);
    chk("rd_lat2", 32'({scan_pix_valid, scan_pix}), 32'b11);

    vbits = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      scan_req = 1'b0;
      case (i)
        0: begin scan_req = 1'b1; scan_x = 2'd3; scan_y = 3'd4; end
        1: begin scan_req = 1'b1; scan_x = 2'd0; scan_y = 3'd2; end
        2: begin scan_req = 1'b1; scan_x = 2'd1; scan_y = 3'd0; end
        3: begin scan_req = 1'b1; scan_x = 2'd2; scan_y = 3'd3; end
        default: ;
      endcase
      if (i < 4) rq.push_back(i != 1);
      @(negedge clock);
      vbits[i] = scan_pix_valid;
    end
    chk("rd_burst_valids", 32'(vbits), 32'h3C);

    @(posedge clock); #1;
    push_cells(15'h1234, 7);
    load_glyph = 15'h1234;
    load_valid = 1'b1;
    @(posedge clock); #1;
    load_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 30) begin
      @(negedge clock);
      if (mem_write) n++;
      cyc++;
      @(posedge clock); #1;
    end
    chk("abort_six", 32'(n), 32'd6);
    scan_req = 1'b1;
    scan_x = 2'd0;
    scan_y = 3'd0;
    @(negedge clock);
    chk("abort_stall", 32'(mem_write), 32'd0);
    @(posedge clock); #1;
    scan_req = 1'b0;
    @(negedge clock);
    chk("abort_7th", 32'(mem_write), 32'd1);
    rst = 1'b1;
    @(negedge clock);
    chk("abort_state",
        32'({busy, load_ready, load_done, mem_write, scan_pix_valid}),
        32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("abort_rel_low", 32'({load_ready, load_done, scan_pix_valid}), 32'd0);
    @(negedge clock);
    chk("abort_rel_ready", 32'({load_ready, load_done}), 32'b10);

    run_load(15'h2BCD, 1'b0);
    repeat (3) @(negedge clock);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
